// File: rtl/flag_tally_if.sv
// Bus between the per-player event sources and the game-over tally logic.
// The tally block uses the slave modport; the event/display side uses the master modport.
interface flag_tally_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 4
);
    localparam int ID_W = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]       trigger;
    logic                  clear;
    logic [N_CH*CNT_W-1:0] count;
    logic                  gameover;
    logic                  gameover_pulse;
    logic [ID_W-1:0]       winner_id;

    modport master (
        output trigger, clear,
        input  count, gameover, gameover_pulse, winner_id
    );

    modport slave (
        input  trigger, clear,
        output count, gameover, gameover_pulse, winner_id
    );
endinterface

// File: rtl/flag_tally.sv
// Multi-channel rising-edge tally; the first channel to reach THRESHOLD ends the game
// and freezes all counters until a synchronous clear.
module flag_tally #(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 4,
    parameter int THRESHOLD = 15
) (
    input  logic         clk,
    input  logic         rst,
    flag_tally_if.slave  bus
);
    localparam int ID_W = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

    typedef enum logic {
        S_RUN,
        S_GAMEOVER
    } state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   trig_q, trig_d;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];
    logic              gameover_q, gameover_d;
    logic              pulse_q, pulse_d;
    logic [ID_W-1:0]   winner_q, winner_d;
    logic [N_CH-1:0]   trig_edge;
    logic              hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            trig_q     <= '1;
            cnt_q      <= '{default: '0};
            gameover_q <= 1'b0;
            pulse_q    <= 1'b0;
            winner_q   <= '0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_d;
            cnt_q      <= cnt_d;
            gameover_q <= gameover_d;
            pulse_q    <= pulse_d;
            winner_q   <= winner_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        trig_d     = bus.trigger;
        cnt_d      = cnt_q;
        gameover_d = gameover_q;
        pulse_d    = 1'b0;
        winner_d   = winner_q;
        hit        = 1'b0;
        trig_edge  = bus.trigger & ~trig_q;

        if (bus.clear) begin
            state_d    = S_RUN;
            cnt_d      = '{default: '0};
            gameover_d = 1'b0;
            winner_d   = '0;
        end else if (state_q == S_RUN) begin
            // Counts stay below THR while running, so +1 can never wrap.
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (trig_edge[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            // Scanned high-to-low so the lowest hitting index wins a tie.
            for (int unsigned i = N_CH; i > 0; i--) begin
                if (cnt_d[i-1] == THR) begin
                    hit      = 1'b1;
                    winner_d = ID_W'(i - 1);
                end
            end
            if (hit) begin
                state_d    = S_GAMEOVER;
                gameover_d = 1'b1;
                pulse_d    = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_pack
        assign bus.count[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign bus.gameover       = gameover_q;
    assign bus.gameover_pulse = pulse_q;
    assign bus.winner_id      = winner_q;
endmodule

// File: tb/tb_flag_tally.sv
// Three flag_tally configurations driven in lockstep and checked every cycle
// against a per-channel integer model of the tally rules.
module tb_flag_tally;
    localparam int NI = 3;
    localparam int NCH [NI] = '{2, 4, 3};
    localparam int CW  [NI] = '{4, 4, 3};
    localparam int THR [NI] = '{15, 3, 7};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  trig [NI];
    logic        clr  [NI];
    logic [15:0] obs_cnt [NI];
    logic        obs_go  [NI];
    logic        obs_pl  [NI];
    logic [1:0]  obs_win [NI];

    flag_tally_if #(.N_CH(2), .CNT_W(4)) if0 ();
    flag_tally_if #(.N_CH(4), .CNT_W(4)) if1 ();
    flag_tally_if #(.N_CH(3), .CNT_W(3)) if2 ();

    flag_tally #(.N_CH(2), .CNT_W(4), .THRESHOLD(15)) u0 (.clk(clk), .rst(rst), .bus(if0));
    flag_tally #(.N_CH(4), .CNT_W(4), .THRESHOLD(3))  u1 (.clk(clk), .rst(rst), .bus(if1));
    flag_tally #(.N_CH(3), .CNT_W(3), .THRESHOLD(7))  u2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.trigger = trig[0][1:0];
    assign if1.trigger = trig[1][3:0];
    assign if2.trigger = trig[2][2:0];
    assign if0.clear = clr[0];
    assign if1.clear = clr[1];
    assign if2.clear = clr[2];

    assign obs_cnt[0] = 16'(if0.count);
    assign obs_cnt[1] = 16'(if1.count);
    assign obs_cnt[2] = 16'(if2.count);
    assign obs_go[0] = if0.gameover;
    assign obs_go[1] = if1.gameover;
    assign obs_go[2] = if2.gameover;
    assign obs_pl[0] = if0.gameover_pulse;
    assign obs_pl[1] = if1.gameover_pulse;
    assign obs_pl[2] = if2.gameover_pulse;
    assign obs_win[0] = 2'(if0.winner_id);
    assign obs_win[1] = 2'(if1.winner_id);
    assign obs_win[2] = 2'(if2.winner_id);

    int   m_cnt  [NI][4];
    bit   [3:0] m_prev [NI];
    bit   m_over  [NI];
    bit   m_pulse [NI];
    int   m_win   [NI];

    int vectors = 0;
    int miscompares = 0;

    function automatic bit [3:0] mask(int k);
        return 4'((1 << NCH[k]) - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
            m_prev[k]  = mask(k);
            m_over[k]  = 1'b0;
            m_pulse[k] = 1'b0;
            m_win[k]   = 0;
        end
    endtask

    task automatic model_step(int k);
        bit [3:0] t;
        bit       found;
        t = trig[k] & mask(k);
        m_pulse[k] = 1'b0;
        if (clr[k]) begin
            for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
            m_over[k] = 1'b0;
            m_win[k]  = 0;
        end else if (!m_over[k]) begin
            found = 1'b0;
            for (int i = 0; i < NCH[k]; i++)
                if (t[i] && !m_prev[k][i]) m_cnt[k][i]++;
            for (int i = 0; i < NCH[k]; i++)
                if (!found && m_cnt[k][i] == THR[k]) begin
                    found = 1'b1;
                    m_win[k] = i;
                end
            if (found) begin
                m_over[k]  = 1'b1;
                m_pulse[k] = 1'b1;
            end
        end
        m_prev[k] = t;
    endtask

    function automatic logic [15:0] exp_cnt(int k);
        logic [15:0] r = '0;
        for (int i = 0; i < NCH[k]; i++) r |= 16'(m_cnt[k][i]) << (i * CW[k]);
        return r;
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("u%0d.count", k),    obs_cnt[k],       exp_cnt(k));
            chk($sformatf("u%0d.gameover", k), 16'(obs_go[k]),   16'(m_over[k]));
            chk($sformatf("u%0d.pulse", k),    16'(obs_pl[k]),   16'(m_pulse[k]));
            chk($sformatf("u%0d.winner", k),   16'(obs_win[k]),  16'(m_win[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_step(k);
        #1;
        check_all();
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            trig[k] = 4'hF;
            clr[k]  = 1'b0;
        end
        model_reset();

        // Reset with all triggers held high; release and hold.
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        repeat (5) tick();
        chk("held_high_not_counted", obs_cnt[0], 16'h0000);
        trig[0] = 4'b0010; tick();
        trig[0] = 4'b0011; tick();
        chk("reraise_ch0", obs_cnt[0], 16'h0001);

        // Defaults: 15 ch0 edges reach the threshold.
        for (int k = 0; k < NI; k++) begin
            trig[k] = 4'h0;
            clr[k]  = 1'b1;
        end
        tick();
        for (int k = 0; k < NI; k++) clr[k] = 1'b0;
        tick();
        for (int r = 0; r < 15; r++) begin
            trig[0] = 4'b0001; tick();
            if (r == 14) chk("pulse_at_15", 16'(obs_pl[0]), 16'h1);
            else         chk("no_go_before_15", 16'(obs_go[0]), 16'h0);
            trig[0] = 4'b0000; tick();
        end
        chk("count_15", obs_cnt[0], 16'h000F);
        chk("go_15", 16'(obs_go[0]), 16'h1);
        chk("pulse_one_cycle", 16'(obs_pl[0]), 16'h0);
        chk("winner_0", 16'(obs_win[0]), 16'h0);
        repeat (3) begin
            trig[0] = 4'b0001; tick();
            trig[0] = 4'b0000; tick();
        end
        chk("frozen_15", obs_cnt[0], 16'h000F);

        // Tie between channels 1 and 2 on the 4-channel instance.
        repeat (2) begin
            trig[1] = 4'b0110; tick();
            trig[1] = 4'b0000; tick();
        end
        chk("tie_pre", obs_cnt[1], 16'h0220);
        trig[1] = 4'b0110; tick();
        chk("tie_count", obs_cnt[1], 16'h0330);
        chk("tie_go", 16'(obs_go[1]), 16'h1);
        chk("tie_winner", 16'(obs_win[1]), 16'h1);
        trig[1] = 4'b0000; tick();

        // Clear out of game-over with an edge in the clear cycle.
        clr[0] = 1'b1; trig[0] = 4'b0001; tick();
        clr[0] = 1'b0;
        chk("clr_count", obs_cnt[0], 16'h0000);
        chk("clr_go", 16'(obs_go[0]), 16'h0);
        trig[0] = 4'b0000; tick();
        trig[0] = 4'b0001; tick();
        chk("after_clr_edge", obs_cnt[0], 16'h0001);

        // Asynchronous reset mid-count.
        trig[0] = 4'b0000; clr[0] = 1'b1; tick();
        clr[0] = 1'b0;
        for (int r = 0; r < 7; r++) begin
            trig[0] = (r < 4) ? 4'b0011 : 4'b0001; tick();
            trig[0] = 4'b0000; tick();
        end
        chk("pre_rst_count", obs_cnt[0], 16'h0047);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_rst_count", obs_cnt[0], 16'h0000);
        #2 rst = 1'b0;
        tick();
        trig[0] = 4'b0001; tick();
        chk("resume_after_rst", obs_cnt[0], 16'h0001);
        trig[0] = 4'b0000; tick();

        // 3-bit counters at threshold 7, channel 2 wins.
        for (int r = 0; r < 7; r++) begin
            trig[2] = 4'b0100; tick();
            trig[2] = 4'b0000; tick();
        end
        chk("c3_count", obs_cnt[2], 16'h01C0);
        chk("c3_go", 16'(obs_go[2]), 16'h1);
        chk("c3_winner", 16'(obs_win[2]), 16'h2);
        for (int r = 0; r < 10; r++) begin
            trig[2] = 4'b0001; tick();
            trig[2] = 4'b0000; tick();
        end
        chk("c3_frozen", obs_cnt[2], 16'h01C0);

        // Randomized traffic with occasional clears.
        for (int r = 0; r < 400; r++) begin
            for (int k = 0; k < NI; k++) begin
                trig[k] = 4'($urandom) & mask(k);
                clr[k]  = ($urandom_range(0, 39) == 0);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/flag_tally.md
Name: flag_tally

Overview:
- Parametrised multi-channel successor to the single-trigger game-over flag counter.
- Each channel counts rising edges on its own trigger. The first channel to reach a programmable threshold ends the game.
- On game-over: sticky flag, one-cycle pulse, registered winner index. All counters freeze until a clear.
- Sits between the per-player win/lose event sources and the game-over display/control logic.

Parameters:
- N_CH, 2, number of trigger channels (players); legal range >= 2.
- CNT_W, 4, width of each channel counter.
- THRESHOLD, 15, count value that ends the game; legal range 1 .. 2^CNT_W-1.
- ID_W, max(1, clog2(N_CH)), winner index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- trigger  in  N_CH  per-channel event level; a 0->1 transition, as sampled on clk, is one event
- clear  in  1  synchronous restart: zeroes counts and returns to RUN
- count  out  N_CH*CNT_W  packed counters; channel i occupies bits [i*CNT_W +: CNT_W]
- gameover  out  1  sticky game-over flag
- gameover_pulse  out  1  one-cycle strobe on entry to GAMEOVER
- winner_id  out  ID_W  index of the winning channel; valid while gameover=1

Behaviour:
- Reset (async, rst=1):
  - state=RUN; all counts=0; gameover=0; gameover_pulse=0; winner_id=0.
  - Edge-history register loads all-ones, so a trigger held high through reset release is not counted.
- Edge detect:
  - trig_q <= trigger every cycle, in every state.
  - edge[i] = trigger[i] & ~trig_q[i].
  - A held-high trigger counts exactly once.
- State RUN:
  - Each channel with edge[i]=1 increments its count by 1 at that clock edge.
  - Channels are independent; simultaneous edges all increment in the same cycle.
  - Latency: count is updated at the first clock edge where trigger is sampled high after being sampled low.
  - Threshold detect uses next-state values: if any channel's next count == THRESHOLD, then at the same edge:
    - state -> GAMEOVER; gameover=1; gameover_pulse=1.
    - winner_id = lowest index whose next count == THRESHOLD (tie rule).
  - All channels that hit THRESHOLD in that cycle keep count=THRESHOLD.
- State GAMEOVER:
  - Counts frozen and edges ignored (trig_q still updates).
  - gameover=1 and winner_id held; gameover_pulse=0 after its single cycle.
- clear (sampled at clk, any state; priority over counting):
  - Next state RUN; counts=0; gameover=0; gameover_pulse=0; winner_id=0.
  - trig_q <= trigger as usual, so a trigger held high across clear is not counted.
  - Edges occurring in the clear cycle are discarded.
- Wrap/saturation: counts never exceed THRESHOLD, so no wrap. THRESHOLD=2^CNT_W-1 is legal and must not overflow the compare.
- rst mid-game: immediate async return to reset values regardless of state or clear.
- rst has priority over clear; clear has priority over counting and threshold detection.
- All outputs are registered; no combinational path from trigger or clear to any output.

Test Plan:
- Reset with trigger=2'b11 held high, release rst, hold for 5 cycles -> count=0, gameover=0 throughout; drop and re-raise ch0 once -> count[3:0]=1.
- Defaults: ch0 toggles once per 2 clk (15 rising edges), ch1 idle -> count[3:0] steps 1..15; gameover and gameover_pulse rise at the edge count reaches 15; pulse lasts one cycle; winner_id=0. Further ch0 edges -> count stays 15.
- THRESHOLD=3, N_CH=4, channels 1 and 2 both at 2, simultaneous edges on both -> both counts=3, gameover=1, winner_id=1 (lowest index).
- After game-over, assert clear one cycle with ch0 toggling -> counts all 0, gameover=0, winner_id=0; edge in clear cycle not counted; next edge -> count=1.
- Assert rst asynchronously mid-count (ch0=7, ch1=4), between clock edges -> all outputs 0 immediately, before next clk edge; counting resumes from 0 after release.
- CNT_W=3, THRESHOLD=7, N_CH=3, ch2 toggling -> reaches 7 without wrap, gameover=1, winner_id=2; 10 more edges on ch0 -> ch0 count stays 0.
